// File: rtl/ifid_pkg.sv
// ifid_pkg -- shared definitions for the IF/ID pipeline stage.
//   ifid_state_e  : skid-buffer occupancy (EMPTY / ONE / TWO)
//   *_LSB / *_W   : bit positions and widths of the instruction fields
//   ifid_fields_t : packed view of one decoded instruction word
package ifid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ifid_state_e;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned SH_LSB  = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned FN_W    = 6;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JA_LSB  = 0;
  localparam int unsigned JA_W    = 26;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic [FN_W-1:0]  funct;
    logic [IMM_W-1:0] imm;
    logic [JA_W-1:0]  jaddr;
  } ifid_fields_t;

endpackage

// File: rtl/ifid_stage_fields.sv
// instr_fields -- purely combinational slicing of a 32-bit instruction word.
//   instr_i  : instruction word
//   fields_o : opcode/rs/rt/rd/shamt/funct/imm/jaddr views (overlapping)
module instr_fields
  import ifid_pkg::*;
(
  input  logic [31:0]  instr_i,
  output ifid_fields_t fields_o
);

  always_comb begin
    fields_o.opcode = instr_i[OPC_LSB +: OPC_W];
    fields_o.rs     = instr_i[RS_LSB  +: REG_W];
    fields_o.rt     = instr_i[RT_LSB  +: REG_W];
    fields_o.rd     = instr_i[RD_LSB  +: REG_W];
    fields_o.shamt  = instr_i[SH_LSB  +: REG_W];
    fields_o.funct  = instr_i[FN_LSB  +: FN_W];
    fields_o.imm    = instr_i[IMM_LSB +: IMM_W];
    fields_o.jaddr  = instr_i[JA_LSB  +: JA_W];
  end

endmodule

// File: rtl/ifid_stage.sv
// ifid_stage -- IF/ID pipeline register built as a 2-entry skid buffer.
//   clk, rst_n (async, active-low), flush (sync discard)
//   fetch side : in_valid, in_ready (registered), in_instr, in_pc
//   decode side: out_valid, out_ready, out_pc and sliced fields
//                out_opcode/rs/rt/rd/shamt/funct/imm/jaddr
//   IFID_STALL_CNT_EN : adds stall_cnt, a saturating count of cycles
//                       with out_valid && !out_ready (cleared by reset only)
module ifid_stage
  import ifid_pkg::*;
#(
  parameter int unsigned n = 32,
  parameter int unsigned i = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_instr,
  input  logic [n-1:0] in_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_pc,
  output logic [5:0]   out_opcode,
  output logic [4:0]   out_rs,
  output logic [4:0]   out_rt,
  output logic [4:0]   out_rd,
  output logic [4:0]   out_shamt,
  output logic [5:0]   out_funct,
  output logic [i-1:0] out_imm,
  output logic [25:0]  out_jaddr
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [31:0]  stall_cnt
`endif
);

  ifid_state_e  state_q, state_d;
  logic         in_ready_q, out_valid_q;
  logic [n-1:0] main_instr_q, main_pc_q;
  logic [n-1:0] skid_instr_q, skid_pc_q;
  logic         accept, deliver;
  logic         load_main_in, load_main_skid, load_skid;
  ifid_fields_t fields;

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid_q && out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: if (accept) begin
        state_d      = ONE;
        load_main_in = 1'b1;
      end
      ONE: begin
        if (accept && !deliver) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (accept) begin
          load_main_in = 1'b1;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: if (deliver) begin
        state_d        = ONE;
        load_main_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Handshake flags are registered from the next state so neither
  // depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      if (load_main_in) begin
        main_instr_q <= in_instr;
        main_pc_q    <= in_pc;
      end else if (load_main_skid) begin
        main_instr_q <= skid_instr_q;
        main_pc_q    <= skid_pc_q;
      end
      if (load_skid) begin
        skid_instr_q <= in_instr;
        skid_pc_q    <= in_pc;
      end
    end
  end

  instr_fields u_fields (
    .instr_i  (32'(main_instr_q)),
    .fields_o (fields)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = main_pc_q;
  assign out_opcode = fields.opcode;
  assign out_rs     = fields.rs;
  assign out_rt     = fields.rt;
  assign out_rd     = fields.rd;
  assign out_shamt  = fields.shamt;
  assign out_funct  = fields.funct;
  assign out_imm    = i'(fields.imm);
  assign out_jaddr  = fields.jaddr;

`ifdef IFID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
module tb_ifid_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm;
  logic [25:0] out_jaddr;
`ifdef IFID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ifid_stage #(.n(32), .i(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_shamt  (out_shamt),
    .out_funct  (out_funct),
    .out_imm    (out_imm),
    .out_jaddr  (out_jaddr)
`ifdef IFID_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_imm",   32'(out_imm),   32'd0);
    chk("rst_out_pc",    out_pc,         32'd0);
    chk("rst_opcode",    32'(out_opcode), 32'd0);
`ifdef IFID_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // single beat, latency 1
    out_ready = 1'b1;
    offer(32'h2008_8000, 32'h0040_0000);
    step();
    in_valid = 1'b0;
    chk("b1_valid",  32'(out_valid),  32'd1);
    chk("b1_opcode", 32'(out_opcode), 32'h08);
    chk("b1_rs",     32'(out_rs),     32'd0);
    chk("b1_rt",     32'(out_rt),     32'd8);
    chk("b1_rd",     32'(out_rd),     32'd16);
    chk("b1_shamt",  32'(out_shamt),  32'd0);
    chk("b1_funct",  32'(out_funct),  32'd0);
    chk("b1_imm",    32'(out_imm),    32'h8000);
    chk("b1_jaddr",  32'(out_jaddr),  32'h0088000);
    chk("b1_pc",     out_pc,          32'h0040_0000);
    step();
    chk("b1_drain_valid", 32'(out_valid), 32'd0);
    chk("b1_drain_ready", 32'(in_ready),  32'd1);

    // back-pressure: 1 and 2 held, 3 stalled, then in-order release
    out_ready = 1'b0;
    offer(32'd1, 32'h100);
    step();
    chk("bp1_ready", 32'(in_ready), 32'd1);
    chk("bp1_imm",   32'(out_imm),  32'd1);
    offer(32'd2, 32'h104);
    step();
    chk("bp2_ready", 32'(in_ready), 32'd0);
    chk("bp2_imm",   32'(out_imm),  32'd1);
    offer(32'd3, 32'h108);
    step();
    chk("bp3_ready",  32'(in_ready),  32'd0);
    chk("bp3_imm",    32'(out_imm),   32'd1);
    chk("bp3_pc",     out_pc,         32'h100);
    chk("bp3_valid",  32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("rel1_imm",   32'(out_imm),  32'd2);
    chk("rel1_pc",    out_pc,        32'h104);
    chk("rel1_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("rel2_imm",   32'(out_imm),   32'd3);
    chk("rel2_pc",    out_pc,         32'h108);
    chk("rel2_valid", 32'(out_valid), 32'd1);
    step();
    chk("rel3_valid", 32'(out_valid), 32'd0);

    // full-rate streaming
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      offer(32'h10 + 32'(k), 32'h200 + 32'(4 * k));
      step();
      chk("str_valid", 32'(out_valid), 32'd1);
      chk("str_imm",   32'(out_imm),   32'h10 + 32'(k));
      chk("str_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("str_end_valid", 32'(out_valid), 32'd0);

    // flush from TWO discards both held beats and the offered one
    out_ready = 1'b0;
    offer(32'hAA, 32'h300);
    step();
    offer(32'hBB, 32'h304);
    step();
    chk("fl_two_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    offer(32'hCC, 32'h308);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    step();
    chk("fl_after1_valid", 32'(out_valid), 32'd0);
    step();
    chk("fl_after2_valid", 32'(out_valid), 32'd0);

    // asynchronous reset while ONE
    out_ready = 1'b0;
    offer(32'h1234_5678, 32'h400);
    step();
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_imm",   32'(out_imm),   32'h5678);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_imm",   32'(out_imm),   32'd0);
    chk("ar_ready", 32'(in_ready),  32'd1);
`ifdef IFID_STALL_CNT_EN
    chk("ar_stall_cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // held output stays stable under back-pressure; stall counting
    offer(32'h0000_0055, 32'h500);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("hold_imm",   32'(out_imm),   32'h55);
    chk("hold_pc",    out_pc,         32'h500);
    chk("hold_valid", 32'(out_valid), 32'd1);
`ifdef IFID_STALL_CNT_EN
    chk("stall_cnt_5", stall_cnt, 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("stall_cnt_flush", stall_cnt, 32'd6);
    step();
    chk("stall_cnt_idle", stall_cnt, 32'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
